// File: rtl/disp_bcd_ctrl.sv
// Display sequencer: converts binary distance samples to four BCD digits with a
// serial double-dabble, rate-limits updates and blanks the display on sensor timeout.
module disp_bcd_ctrl #(
    parameter int DIN_W       = 14,
    parameter int HOLD_CNT    = 5_000_000,
    parameter int TIMEOUT_CNT = 50_000_000
) (
    input  logic             sys_clk50m,
    input  logic             sys_rst,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [3:0]       A0,
    output logic [3:0]       A1,
    output logic [3:0]       A2,
    output logic [3:0]       A3,
    output logic             ovf,
    output logic             stale,
    output logic             upd
);

    localparam int BIT_W  = $clog2(DIN_W + 1);
    localparam int HOLD_W = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CNT);

    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(DIN_W);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CNT - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CNT - 1);
    localparam logic [DIN_W-1:0]  DIN_CLAMP = DIN_W'(9999);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic [DIN_W-1:0]    r_bin;
    logic [15:0]         r_bcd;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_ovf_pend;
    logic [15:0]         r_digits;
    logic                r_ovf;
    logic                r_stale;
    logic                r_upd;
    logic                r_din_ready;

    state_t              w_state_next;
    logic [DIN_W-1:0]    w_bin_next;
    logic [15:0]         w_bcd_next;
    logic [BIT_W-1:0]    w_bit_cnt_next;
    logic [HOLD_W-1:0]   w_hold_cnt_next;
    logic [TO_W-1:0]     w_to_cnt_next;
    logic                w_ovf_pend_next;
    logic [15:0]         w_digits_next;
    logic                w_ovf_next;
    logic                w_stale_next;
    logic                w_upd_next;

    logic [15:0]         w_bcd_adj;
    logic [15:0]         w_bcd_sat;
    logic [DIN_W+15:0]   w_shift;
    logic                w_din_over;
    logic [DIN_W-1:0]    w_din_clamped;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
            // Guard so a corrupted accumulator can never show an illegal glyph.
            assign w_bcd_sat[gi*4 +: 4] = (r_bcd[gi*4 +: 4] > 4'd9) ?
                                          4'd9 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_shift       = {w_bcd_adj, r_bin} << 1;
    assign w_din_over    = (32'(din) > 32'd9999);
    assign w_din_clamped = w_din_over ? DIN_CLAMP : din;

    always_comb begin
        w_state_next    = r_state;
        w_bin_next      = r_bin;
        w_bcd_next      = r_bcd;
        w_bit_cnt_next  = r_bit_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_to_cnt_next   = r_to_cnt;
        w_ovf_pend_next = r_ovf_pend;
        w_digits_next   = r_digits;
        w_ovf_next      = r_ovf;
        w_stale_next    = r_stale;
        w_upd_next      = 1'b0;

        // Any strobe, accepted or dropped, proves the sensor is alive.
        if (din_valid) begin
            w_to_cnt_next = '0;
        end else if (r_to_cnt != TO_MAX) begin
            w_to_cnt_next = r_to_cnt + 1'b1;
        end else if (!r_stale) begin
            w_stale_next  = 1'b1;
            w_digits_next = '0;
            w_ovf_next    = 1'b0;
            w_upd_next    = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (din_valid) begin
                    w_bin_next      = w_din_clamped;
                    w_ovf_pend_next = w_din_over;
                    w_bcd_next      = '0;
                    w_bit_cnt_next  = BIT_LOAD;
                    w_state_next    = CONV;
                end
            end
            CONV: begin
                if (r_bit_cnt != '0) begin
                    w_bcd_next     = w_shift[DIN_W+15:DIN_W];
                    w_bin_next     = w_shift[DIN_W-1:0];
                    w_bit_cnt_next = r_bit_cnt - 1'b1;
                end else begin
                    w_digits_next   = w_bcd_sat;
                    w_ovf_next      = r_ovf_pend;
                    w_stale_next    = 1'b0;
                    w_upd_next      = 1'b1;
                    w_hold_cnt_next = HOLD_LOAD;
                    w_state_next    = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk50m or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_ovf_pend  <= 1'b0;
            r_digits    <= '0;
            r_ovf       <= 1'b0;
            r_stale     <= 1'b0;
            r_upd       <= 1'b0;
            r_din_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_bin       <= w_bin_next;
            r_bcd       <= w_bcd_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_to_cnt    <= w_to_cnt_next;
            r_ovf_pend  <= w_ovf_pend_next;
            r_digits    <= w_digits_next;
            r_ovf       <= w_ovf_next;
            r_stale     <= w_stale_next;
            r_upd       <= w_upd_next;
            r_din_ready <= (w_state_next == IDLE);
        end
    end

    assign din_ready = r_din_ready;
    assign A0        = r_digits[3:0];
    assign A1        = r_digits[7:4];
    assign A2        = r_digits[11:8];
    assign A3        = r_digits[15:12];
    assign ovf       = r_ovf;
    assign stale     = r_stale;
    assign upd       = r_upd;

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// Randomized self-checking bench for disp_bcd_ctrl against a decimal-arithmetic model.
module tb_disp_bcd_ctrl;

    localparam int DIN_W       = 14;
    localparam int HOLD_CNT    = 8;
    localparam int TIMEOUT_CNT = 100;
    localparam int DONE_EDGE   = DIN_W + 1;
    localparam int READY_EDGE  = DIN_W + 1 + HOLD_CNT;

    logic             clk;
    logic             sys_rst;
    logic [DIN_W-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [3:0]       A0, A1, A2, A3;
    logic             ovf, stale, upd;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;

    logic [15:0] exp_digits = '0;
    logic        exp_ovf    = 1'b0;
    logic        exp_stale  = 1'b0;

    disp_bcd_ctrl #(
        .DIN_W(DIN_W), .HOLD_CNT(HOLD_CNT), .TIMEOUT_CNT(TIMEOUT_CNT)
    ) dut (
        .sys_clk50m(clk), .sys_rst(sys_rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .ovf(ovf), .stale(stale), .upd(upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (sys_rst && upd) upd_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Decimal digits of the displayed value, from plain arithmetic.
    function automatic logic [15:0] model_digits(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {A3, A2, A1, A0};
    endfunction

    // Strobes v when ready, then checks every cycle up to ready returning.
    // drop_at in 0..HOLD_CNT-2 strobes a random sample during HOLD that must be ignored.
    task automatic do_sample(input int v, input int drop_at);
        int waited;
        int u0;
        waited = 0;
        while (!din_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!din_ready) begin
            check("ready_wait", 32'(din_ready), 32'd1);
            return;
        end
        u0 = upd_cnt;
        din = DIN_W'(v);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check("ready_after_T", 32'(din_ready), 32'd0);
        for (int i = 0; i <= READY_EDGE; i++) begin
            if (i > 0) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
            if (i < DONE_EDGE) begin
                check("upd_early", 32'(upd), 32'd0);
                check("ready_conv", 32'(din_ready), 32'd0);
                check("digits_old", 32'(shown()), 32'(exp_digits));
                check("stale_old", 32'(stale), 32'(exp_stale));
            end else if (i == DONE_EDGE) begin
                exp_digits = model_digits(v);
                exp_ovf    = (v > 9999);
                exp_stale  = 1'b0;
                check("upd_pulse", 32'(upd), 32'd1);
                check("digits", 32'(shown()), 32'(exp_digits));
                check("ovf", 32'(ovf), 32'(exp_ovf));
                check("stale_clr", 32'(stale), 32'd0);
            end else begin
                check("upd_hold", 32'(upd), 32'd0);
                check("ready_hold", 32'(din_ready), 32'(i == READY_EDGE));
                check("digits_hold", 32'(shown()), 32'(exp_digits));
                if (i - DONE_EDGE - 1 == drop_at) begin
                    din = DIN_W'($urandom_range(0, 16383));
                    din_valid = 1'b1;
                end
            end
        end
        check("upd_count", 32'(upd_cnt - u0), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int u0;
        sys_rst   = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        #2 sys_rst = 1'b0;
        #1;
        check("rst_digits", 32'(shown()), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd1);
        check("rst_flags", 32'({ovf, stale, upd}), 32'd0);
        idle_cycles(3);
        sys_rst = 1'b1;
        idle_cycles(2);

        do_sample(1234, -1);
        do_sample(0, -1);
        do_sample(9999, -1);
        do_sample(10000, -1);
        do_sample(7, -1);

        do_sample(1234, 2);
        do_sample(5555, -1);

        // Stale: last strobe was edge T, do_sample returns after edge T+READY_EDGE.
        do_sample(42, -1);
        idle_cycles(TIMEOUT_CNT - 1 - READY_EDGE);
        check("stale_pre", 32'(stale), 32'd0);
        check("upd_pre", 32'(upd), 32'd0);
        u0 = upd_cnt;
        @(negedge clk);
        exp_digits = '0;
        exp_ovf    = 1'b0;
        exp_stale  = 1'b1;
        check("stale_set", 32'(stale), 32'd1);
        check("stale_upd", 32'(upd), 32'd1);
        check("stale_digits", 32'(shown()), 32'd0);
        check("stale_ovf", 32'(ovf), 32'd0);
        idle_cycles(300);
        check("stale_one_upd", 32'(upd_cnt - u0), 32'd1);
        check("stale_hold", 32'(stale), 32'd1);
        do_sample(42, -1);

        // Strobe lands exactly on the expiry edge.
        do_sample(9876, -1);
        idle_cycles(TIMEOUT_CNT - 1 - READY_EDGE);
        do_sample(555, -1);
        check("expiry_no_stale", 32'(stale), 32'd0);

        // Asynchronous reset mid-conversion.
        do_sample(10000, -1);
        din = DIN_W'(8888);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        u0 = upd_cnt;
        idle_cycles(5);
        sys_rst = 1'b0;
        #1;
        exp_digits = '0;
        exp_ovf    = 1'b0;
        exp_stale  = 1'b0;
        check("arst_digits", 32'(shown()), 32'd0);
        check("arst_ready", 32'(din_ready), 32'd1);
        check("arst_flags", 32'({ovf, stale, upd}), 32'd0);
        idle_cycles(2);
        sys_rst = 1'b1;
        idle_cycles(20);
        check("arst_no_upd", 32'(upd_cnt - u0), 32'd0);
        check("arst_digits_kept", 32'(shown()), 32'd0);
        do_sample(321, -1);

        // Random samples, random gaps, random dropped strobes during HOLD.
        for (int k = 0; k < 20; k++) begin
            int v;
            int drop;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                            : int'($urandom_range(0, 9999));
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, HOLD_CNT - 2)) : -1;
            idle_cycles($urandom_range(0, 20));
            do_sample(v, drop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
